modsub_arb: RTL and testbench



---
 rtl/modsub_arb_pkg.sv | 21 ++
 rtl/modsub_arb_if.sv | 30 +++
 rtl/modsub_arb_modsub.sv | 62 ++++++
 rtl/modsub_arb.sv | 170 +++++++++++++++++
 tb/tb_modsub_arb.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/modsub_arb_pkg.sv
// modsub_arb_pkg: shared types for the modsub arbiter slice.
// Exports modsub_params_t, modsub_lat() and the arbiter FSM state enum.
package modsub_arb_pkg;

  typedef struct packed {
    logic ff_in;
    logic ff_sub;
    logic ff_out;
  } modsub_params_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    LOAD  = 2'd2
  } modsub_arb_state_t;

  function automatic int modsub_lat(modsub_params_t p);
    return int'(p.ff_in) + int'(p.ff_sub) + int'(p.ff_out);
  endfunction

endpackage

// File: rtl/modsub_arb_if.sv
// modsub_arb_if: requester, config and result bundle of modsub_arb.
// master = requesters/config side, slave = the arbiter.
interface modsub_arb_if #(
  parameter int NREQ  = 4,
  parameter int LOGQ  = 64,
  parameter int LOGQH = 47,
  parameter int IDW   = $clog2(NREQ)
);
  logic [NREQ-1:0]      in_valid;
  logic [NREQ-1:0]      in_ready;
  logic [NREQ*LOGQ-1:0] in_a;
  logic [NREQ*LOGQ-1:0] in_b;
  logic                 cfg_valid;
  logic [LOGQH-1:0]     cfg_qH;
  logic                 cfg_ready;
  logic                 out_valid;
  logic [IDW-1:0]       out_id;
  logic [LOGQ-1:0]      out_c;
  logic                 busy;

  modport master (
    output in_valid, in_a, in_b, cfg_valid, cfg_qH,
    input  in_ready, cfg_ready, out_valid, out_id, out_c, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, cfg_valid, cfg_qH,
    output in_ready, cfg_ready, out_valid, out_id, out_c, busy
  );
endinterface

// File: rtl/modsub_arb_modsub.sv
// modsub_arb_modsub: pipelined c = (a - b) mod q, q = (qh << (LOGQ-LOGQH-1)) + 1.
// Ports: clk, qh (modulus high part), a/b operands (< q), c result.
module modsub_arb_modsub #(
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 47,
  parameter bit FF_IN  = 1'b1,
  parameter bit FF_SUB = 1'b1,
  parameter bit FF_OUT = 1'b1
) (
  input  logic             clk,
  input  logic [LOGQH-1:0] qh,
  input  logic [LOGQ-1:0]  a,
  input  logic [LOGQ-1:0]  b,
  output logic [LOGQ-1:0]  c
);
  localparam int SH = LOGQ - LOGQH - 1;

  logic [LOGQ-1:0] q;
  logic [LOGQ-1:0] a_s;
  logic [LOGQ-1:0] b_s;
  logic [LOGQ:0]   diff_d;
  logic [LOGQ:0]   diff_s;
  logic [LOGQ-1:0] c_d;

  assign q = (LOGQ'(qh) << SH) + LOGQ'(1);

  if (FF_IN) begin : g_ff_in
    logic [LOGQ-1:0] a_q;
    logic [LOGQ-1:0] b_q;
    always_ff @(posedge clk) begin
      a_q <= a;
      b_q <= b;
    end
    assign a_s = a_q;
    assign b_s = b_q;
  end else begin : g_no_in
    assign a_s = a;
    assign b_s = b;
  end

  // top bit is the borrow
  assign diff_d = {1'b0, a_s} - {1'b0, b_s};

  if (FF_SUB) begin : g_ff_sub
    logic [LOGQ:0] diff_q;
    always_ff @(posedge clk) diff_q <= diff_d;
    assign diff_s = diff_q;
  end else begin : g_no_sub
    assign diff_s = diff_d;
  end

  assign c_d = diff_s[LOGQ] ? diff_s[LOGQ-1:0] + q
                            : diff_s[LOGQ-1:0];

  if (FF_OUT) begin : g_ff_out
    logic [LOGQ-1:0] c_q;
    always_ff @(posedge clk) c_q <= c_d;
    assign c = c_q;
  end else begin : g_no_out
    assign c = c_d;
  end
endmodule

// File: rtl/modsub_arb.sv
// modsub_arb: round-robin share of one modsub among NREQ requesters, owns qH.
// Ports: clk, rst_n, bus (slave: requests, config handshake, tagged results, busy).
module modsub_arb
  import modsub_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int LOGQ   = 64,
  parameter int LOGQH  = 47,
  parameter bit FF_IN  = 1'b1,
  parameter bit FF_SUB = 1'b1,
  parameter bit FF_OUT = 1'b1,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic        clk,
  input  logic        rst_n,
  modsub_arb_if.slave bus
);
  localparam modsub_params_t P = '{
    ff_in: FF_IN, ff_sub: FF_SUB, ff_out: FF_OUT
  };
  localparam int LAT = modsub_lat(P);
  localparam int CW  = $clog2(LAT + 1);

  if (LAT < 1 || NREQ < 2 || LOGQH >= LOGQ) begin : g_bad_cfg
    $error("modsub_arb: need LAT>=1, NREQ>=2, LOGQH<LOGQ");
  end

  modsub_arb_state_t state_q, state_d;

  logic [IDW-1:0]          ptr_q, ptr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [LOGQH-1:0]        qh_q, qh_d;
  logic                    cfg_rdy_q, cfg_rdy_d;
  logic                    busy_q, busy_d;
  logic [LAT-1:0]          tv_q, tv_d;
  logic [LAT-1:0][IDW-1:0] tid_q, tid_d;

  logic            can_issue;
  logic            issue;
  logic            out_v;
  logic            lo_hit, hi_hit;
  logic [IDW-1:0]  lo_id, hi_id, gnt_id;
  logic [NREQ-1:0] gnt;
  logic [LOGQ-1:0] op_a, op_b;

  assign can_issue = rst_n && (state_q == RUN) && !bus.cfg_valid;
  assign out_v     = tv_q[LAT-1];

  // first valid at/after ptr, else wrap to lowest valid
  always_comb begin
    lo_hit = 1'b0;
    hi_hit = 1'b0;
    lo_id  = '0;
    hi_id  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.in_valid[i]) begin
        lo_hit = 1'b1;
        lo_id  = IDW'(i);
      end
      if (bus.in_valid[i] && IDW'(i) >= ptr_q) begin
        hi_hit = 1'b1;
        hi_id  = IDW'(i);
      end
    end
    issue  = can_issue && lo_hit;
    gnt_id = issue ? (hi_hit ? hi_id : lo_id) : '0;
    gnt    = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt[i] = issue && (gnt_id == IDW'(i));
    end
  end

  // idle operands held at zero to keep the datapath quiet
  always_comb begin
    op_a = '0;
    op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        op_a = bus.in_a[i*LOGQ +: LOGQ];
        op_b = bus.in_b[i*LOGQ +: LOGQ];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
    end

    cnt_d = cnt_q;
    if (issue && !out_v) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!issue && out_v) begin
      cnt_d = cnt_q - 1'b1;
    end

    tv_d     = '0;
    tid_d    = '0;
    tv_d[0]  = issue;
    tid_d[0] = gnt_id;
    for (int i = 1; i < LAT; i++) begin
      tv_d[i]  = tv_q[i-1];
      tid_d[i] = tid_q[i-1];
    end
  end

  // qH only moves in LOAD, after the pipe has fully drained
  always_comb begin
    state_d = state_q;
    qh_d    = qh_q;
    unique case (state_q)
      RUN:   if (bus.cfg_valid) state_d = DRAIN;
      DRAIN: if (cnt_d == '0) state_d = LOAD;
      LOAD: begin
        state_d = RUN;
        qh_d    = bus.cfg_qH;
      end
      default: state_d = RUN;
    endcase
    cfg_rdy_d = (state_d == LOAD);
    busy_d    = (cnt_d != '0) || (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      ptr_q     <= '0;
      cnt_q     <= '0;
      qh_q      <= '0;
      cfg_rdy_q <= 1'b0;
      busy_q    <= 1'b0;
      tv_q      <= '0;
      tid_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      qh_q      <= qh_d;
      cfg_rdy_q <= cfg_rdy_d;
      busy_q    <= busy_d;
      tv_q      <= tv_d;
      tid_q     <= tid_d;
    end
  end

  a_cnt_max: assert property (
    @(posedge clk) disable iff (!rst_n) int'(cnt_q) <= LAT
  );

  modsub_arb_modsub #(
    .LOGQ   (LOGQ),
    .LOGQH  (LOGQH),
    .FF_IN  (FF_IN),
    .FF_SUB (FF_SUB),
    .FF_OUT (FF_OUT)
  ) u_modsub (
    .clk (clk),
    .qh  (qh_q),
    .a   (op_a),
    .b   (op_b),
    .c   (bus.out_c)
  );

  assign bus.in_ready  = gnt;
  assign bus.cfg_ready = cfg_rdy_q;
  assign bus.out_valid = out_v;
  assign bus.out_id    = tid_q[LAT-1];
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_modsub_arb.sv
// tb_modsub_arb: directed bench for modsub_arb (vector table plus sequences).
// Drives at negedge, checks registered outputs at negedge, in_ready 1ns later.
module tb_modsub_arb;
  localparam int NREQ  = 4;
  localparam int LOGQ  = 64;
  localparam int LOGQH = 47;
  localparam int IDW   = 2;
  localparam int LAT   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  modsub_arb_if #(
    .NREQ(NREQ), .LOGQ(LOGQ), .LOGQH(LOGQH), .IDW(IDW)
  ) bus ();

  modsub_arb #(
    .NREQ(NREQ), .LOGQ(LOGQ), .LOGQH(LOGQH),
    .FF_IN(1'b1), .FF_SUB(1'b1), .FF_OUT(1'b1), .IDW(IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int             due;
    logic [IDW-1:0] id;
    logic [63:0]    c;
  } exp_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    a;
    logic [63:0]    b;
    logic [63:0]    c;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   iter  = 0;
  bit   in_cfg = 1'b0;
  logic [63:0] qcur;
  exp_t expq[$];
  vec_t vt[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (iter %0d)",
               nm, act, exp, iter);
    end
  endtask

  function automatic logic [IDW-1:0] oh2id(input logic [3:0] oh);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = IDW'(i);
    return r;
  endfunction

  function automatic logic [63:0] mref(input logic [63:0] a,
                                       input logic [63:0] b,
                                       input logic [63:0] q);
    return (a >= b) ? a - b : a + q - b;
  endfunction

  task automatic set_req(input int i, input logic [63:0] a,
                         input logic [63:0] b);
    bus.in_a[i*LOGQ +: LOGQ] = a;
    bus.in_b[i*LOGQ +: LOGQ] = b;
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    iter++;
    if (expq.size() > 0 && expq[0].due == iter) begin
      e = expq.pop_front();
      chk("out_valid", 64'(bus.out_valid), 64'd1);
      chk("out_id", 64'(bus.out_id), 64'(e.id));
      chk("out_c", bus.out_c, e.c);
    end else begin
      chk("out_valid_idle", 64'(bus.out_valid), 64'd0);
    end
    if (!in_cfg) chk("cfg_ready_idle", 64'(bus.cfg_ready), 64'd0);
  endtask

  task automatic drive(input logic [3:0] vld, input logic [3:0] rdy,
                       input logic [63:0] c);
    exp_t e;
    bus.in_valid = vld;
    #1;
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (rdy != 4'b0) begin
      e.due = iter + LAT;
      e.id  = oh2id(rdy);
      e.c   = c;
      expq.push_back(e);
    end
  endtask

  task automatic do_cfg(input logic [LOGQH-1:0] qh, input int exp_n);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    in_cfg = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_qH    = qh;
    bus.in_valid  = 4'hF;
    #1;
    chk("cfg_no_grant", 64'(bus.in_ready), 64'd0);
    while (!seen && n < 20) begin
      tick();
      n++;
      if (bus.cfg_ready) seen = 1'b1;
      #1;
      chk("cfg_hold_no_grant", 64'(bus.in_ready), 64'd0);
    end
    chk("cfg_latency", 64'(n), 64'(exp_n));
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 4'h0;
    in_cfg = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] oh;
    logic [63:0] fa, fb;
    bus.in_valid  = 4'h0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_qH    = '0;
    qcur = 64'd1;

    vt = '{
      '{2'd0, 64'd5,     64'd3,     64'd2},
      '{2'd2, 64'd3,     64'd5,     64'd65535},
      '{2'd1, 64'd0,     64'd0,     64'd0},
      '{2'd3, 64'd65536, 64'd1,     64'd65535},
      '{2'd1, 64'd1,     64'd65536, 64'd2},
      '{2'd0, 64'd65536, 64'd65536, 64'd0},
      '{2'd3, 64'd100,   64'd200,   64'd65437}
    };

    // reset state
    rst_n = 1'b0;
    bus.in_valid = 4'hF;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_id", 64'(bus.out_id), 64'd0);
    chk("rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    bus.in_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // load qH=1 from idle: cfg_ready two cycles after cfg_valid
    do_cfg(47'd1, 2);
    qcur = 64'd65537;
    chk("idle_busy", 64'(bus.busy), 64'd0);

    // single-requester vectors, issued back to back
    foreach (vt[i]) begin
      set_req(int'(vt[i].id), vt[i].a, vt[i].b);
      oh = 4'b0001 << vt[i].id;
      drive(oh, oh, vt[i].c);
      tick();
    end
    bus.in_valid = 4'h0;
    repeat (LAT) tick();

    // fairness under full load, then busy drop after the last result
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) begin
        set_req(i, 64'(100 * k + 7 * i), 64'(37 * i + 150 * (k % 3)));
      end
      fa = 64'(100 * k + 7 * (k % 4));
      fb = 64'(37 * (k % 4) + 150 * (k % 3));
      oh = 4'b0001 << (k % 4);
      drive(4'hF, oh, mref(fa, fb, qcur));
      tick();
      chk("busy_stream", 64'(bus.busy), 64'd1);
    end
    bus.in_valid = 4'h0;
    tick();
    tick();
    chk("busy_last_out", 64'(bus.busy), 64'd1);
    tick();
    chk("busy_drop", 64'(bus.busy), 64'd0);
    chk("fair_drained", 64'(expq.size()), 64'd0);

    // reconfiguration with three ops in flight
    set_req(0, 64'd1, 64'd2);
    set_req(1, 64'd7, 64'd9);
    set_req(2, 64'd0, 64'd65536);
    drive(4'b0001, 4'b0001, 64'd65536);
    tick();
    drive(4'b0010, 4'b0010, 64'd65535);
    tick();
    drive(4'b0100, 4'b0100, 64'd1);
    tick();
    do_cfg(47'd2, 3);
    qcur = 64'd131073;
    set_req(3, 64'd0, 64'd1);
    drive(4'b1000, 4'b1000, 64'd131072);
    tick();
    bus.in_valid = 4'h0;
    repeat (LAT) tick();

    // reset with ops in flight and a config pending
    set_req(0, 64'd10, 64'd4);
    set_req(1, 64'd11, 64'd4);
    drive(4'b0001, 4'b0001, 64'd6);
    tick();
    drive(4'b0010, 4'b0010, 64'd7);
    tick();
    bus.in_valid  = 4'h0;
    bus.cfg_valid = 1'b1;
    bus.cfg_qH    = 47'd5;
    tick();
    rst_n = 1'b0;
    expq.delete();
    bus.in_valid = 4'hF;
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid_rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 4'h0;
    repeat (5) tick();
    chk("post_rst_busy", 64'(bus.busy), 64'd0);
    // qH back to 0 gives q=1; ptr back to 0 grants req0 first
    qcur = 64'd1;
    set_req(0, 64'd0, 64'd1);
    drive(4'hF, 4'b0001, mref(64'd0, 64'd1, qcur));
    tick();
    bus.in_valid = 4'h0;
    repeat (LAT) tick();
    chk("final_drained", 64'(expq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
